instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Fetch/issue sequencer that drives the opcode side of the control-unit interface.
- Fetches 8-bit instruction words from program memory over a req/ack handshake and latches them into an instruction register (IR).
- Presents IR[7:5] as the 3-bit opcode to the control unit, then consumes the control unit's jump decision to update the program counter (PC).
- Sits between program memory and the control unit; one instruction in flight at a time.

Parameters:
- ADDR_W, 5, PC and memory address width; operand field width is also ADDR_W.
- DATA_W, 8, instruction width; must equal 3 + ADDR_W.
- TIMEOUT_CYCLES, 15, fetch watchdog limit; used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- run  in  1  level; starts or continues sequencing from IDLE.
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  fetch address; always equals pc.
- mem_ack  in  1  one-cycle data-valid strobe from memory.
- mem_rdata  in  DATA_W  instruction word; valid when mem_ack=1.
- opcode  out  3  IR[7:5], driven to the control unit.
- operand  out  ADDR_W  IR[4:0]; also the jump target.
- exec_valid  out  1  high for exactly the one EXECUTE cycle.
- jump  in  1  from control unit; sampled only in EXECUTE.
- pc  out  ADDR_W  current program counter.
- halted  out  1  high while in HALT.
- fault  out  1  sticky fetch-timeout flag; tied 0 when the optional feature is off.

Behaviour:
- Reset (synchronous, when rst=1 at a rising edge): state=IDLE, pc=0, IR=0, mem_req=0, exec_valid=0, halted=0, fault=0.
  - opcode and operand therefore read 0 after reset.
  - rst overrides everything in every state, including mid-handshake; any in-flight ack is discarded.
- States:
  - IDLE → FETCH when run=1; otherwise stay.
  - FETCH: assert mem_req=1 with mem_addr=pc; → WAIT next cycle.
  - WAIT: hold mem_req=1 and mem_addr stable until mem_ack=1.
    - On ack: IR←mem_rdata, mem_req←0, → DECODE.
    - An ack arriving in the FETCH cycle is also accepted, with the same effect.
  - DECODE: one cycle; opcode/operand stable so the combinational control unit settles; → EXECUTE.
  - EXECUTE: one cycle; exec_valid=1.
    - If jump=1: pc←operand.
    - Else: pc←pc+1, wrapping modulo 2^ADDR_W (31→0).
    - Next state: opcode=3'b111 → HALT; run=0 → IDLE; otherwise → FETCH.
  - HALT: halted=1, no requests issued; leave only by rst.
- mem_ack in IDLE, DECODE, EXECUTE or HALT is ignored.
- Latency: with mem_ack in the first WAIT cycle, one instruction takes 4 cycles (FETCH, WAIT, DECODE, EXECUTE). Each extra wait cycle adds 1.
- The jump input is a don't-care outside EXECUTE.
- opcode/operand change only on an IR load or on reset.
- Dropping run mid-instruction does not abort it; the check happens at EXECUTE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit (minimum) counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops, fault←1 (sticky) and state→HALT (halted=1). pc and IR are unchanged.
  - An ack in the same cycle the count reaches the limit wins: normal load, no fault.
- Undefined: no counter; WAIT persists indefinitely; fault is constant 0.

Test Plan:
- Reset then run=1; memory returns 8'b000_00011 at addr 0 with 0 wait cycles → mem_req high cycles 1-2, opcode=000, operand=3, exec_valid pulse at cycle 4, pc=1.
- Same instruction but jump=1 during EXECUTE → pc=3; next mem_addr=3.
- pc=31, jump=0 → pc wraps to 0 and the next fetch is at addr 0.
- Ack delayed 5 cycles → mem_req held and mem_addr stable throughout; instruction completes in 9 cycles. With FETCH_TIMEOUT_EN and no ack for 15 cycles → fault=1, halted=1, mem_req=0.
- Fetch 8'b111_00000 → after EXECUTE halted=1, no further mem_req; run toggling has no effect until rst.
- Assert rst during WAIT → next cycle state=IDLE, mem_req=0, pc=0; a late mem_ack is ignored.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
//   Fetch/issue sequencer for a small control unit. It fetches one 8-bit
//   instruction at a time from program memory over a req/ack handshake and
//   latches it into the IR. It presents IR[7:5] as the opcode and IR[4:0] as
//   the operand. The control unit's jump decision, taken in EXECUTE, updates
//   the PC.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     Defined   : a WAIT-state watchdog halts the sequencer with a sticky
//                 fault after TIMEOUT_CYCLES wait cycles with no ack.
//     Undefined : WAIT persists indefinitely and fault is tied to 0.
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              exec_valid,
    input  logic              jump,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault
);

    // The instruction format is a 3-bit opcode followed by an ADDR_W-bit
    // operand. The watchdog limit must be reachable.
    if (DATA_W != 3 + ADDR_W) begin : g_bad_width
        $error("instr_fetch_seq: DATA_W must equal 3 + ADDR_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("instr_fetch_seq: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_ir;
    logic                r_mem_req;
    logic                r_exec_valid;
    logic                r_halted;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [2:0]          w_opcode;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 4;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_fault;
`endif

    assign w_opcode  = r_ir[DATA_W-1 -: 3];
    // Jump target is the operand field; the increment wraps naturally at 2^ADDR_W.
    assign w_pc_next = jump ? r_ir[ADDR_W-1:0] : r_pc + 1'b1;

    // Sequencer FSM: state, PC, IR and all registered handshake/status outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) assignments so every
        // register samples pre-edge values, which keeps simulation and
        // synthesis in agreement. The reset here is synchronous, so rst is
        // only seen at a rising edge and is left out of the sensitivity list.
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_mem_req    <= 1'b0;
            r_exec_valid <= 1'b0;
            r_halted     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_fault      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end
                end

                S_FETCH: begin
                    // A fast memory may ack in the same cycle as the request.
                    if (mem_ack) begin
                        r_ir      <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end else begin
                        r_state   <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end

                S_WAIT: begin
                    if (mem_ack) begin
                        r_ir      <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // An ack on the limit cycle takes priority over the timeout.
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                        r_halted  <= 1'b1;
                        r_state   <= S_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                S_DECODE: begin
                    r_exec_valid <= 1'b1;
                    r_state      <= S_EXECUTE;
                end

                S_EXECUTE: begin
                    r_exec_valid <= 1'b0;
                    r_pc         <= w_pc_next;
                    // The run level is checked only here, so the current
                    // instruction always completes.
                    if (w_opcode == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (run) begin
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_pc;
    assign pc         = r_pc;
    assign opcode     = w_opcode;
    assign operand    = r_ir[ADDR_W-1:0];
    assign exec_valid = r_exec_valid;
    assign halted     = r_halted;
`ifdef FETCH_TIMEOUT_EN
    assign fault      = r_fault;
`else
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_seq
//   Directed self-checking bench for instr_fetch_seq. Inputs are driven and
//   outputs sampled on the falling clock edge. The memory handshake is played
//   by hand from the scenario tasks. Honours FETCH_TIMEOUT_EN when defined.
// -----------------------------------------------------------------------------
module tb_instr_fetch_seq;

    logic       clk;
    logic       rst;
    logic       run;
    logic       mem_req;
    logic [4:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       exec_valid;
    logic       jump;
    logic [4:0] pc;
    logic       halted;
    logic       fault;

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch_seq #(
        .ADDR_W(5),
        .DATA_W(8),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .opcode    (opcode),
        .operand   (operand),
        .exec_valid(exec_valid),
        .jump      (jump),
        .pc        (pc),
        .halted    (halted),
        .fault     (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next falling edge (one rising edge has elapsed).
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; jump = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_total++;
        if ({mem_req, exec_valid, halted, fault, pc, opcode, operand} !== 16'h0)
            $display("FAIL reset_state: got req=%b ev=%b halt=%b fault=%b pc=%0d op=%b opd=%0d, want all 0",
                     mem_req, exec_valid, halted, fault, pc, opcode, operand);
        else n_pass++;
        tick();
        n_total++;
        if (mem_req !== 1'b0)
            $display("FAIL idle_no_run: mem_req got %b want 0", mem_req);
        else n_pass++;
    endtask

    // Run one instruction. On entry the DUT is in FETCH (already sampled at a
    // falling edge). On exit the falling edge right after EXECUTE is sampled.
    task automatic exec_instr(input logic [7:0] data, input int waits,
                              input logic jmp, input logic [4:0] addr,
                              input logic [4:0] exp_pc);
        n_total++;
        if ({mem_req, mem_addr} !== {1'b1, addr})
            $display("FAIL fetch_req: got req=%b addr=%0d want req=1 addr=%0d",
                     mem_req, mem_addr, addr);
        else n_pass++;
        tick();
        for (int w = 0; w < waits; w++) begin
            n_total++;
            if ({mem_req, mem_addr, exec_valid} !== {1'b1, addr, 1'b0})
                $display("FAIL wait_hold[%0d]: got req=%b addr=%0d ev=%b want req=1 addr=%0d ev=0",
                         w, mem_req, mem_addr, exec_valid, addr);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({mem_req, mem_addr} !== {1'b1, addr})
            $display("FAIL wait_ack_cycle: got req=%b addr=%0d want req=1 addr=%0d",
                     mem_req, mem_addr, addr);
        else n_pass++;
        mem_ack = 1'b1; mem_rdata = data;
        tick();
        mem_ack = 1'b0; mem_rdata = ~data;
        jump = ~jmp;  // don't-care outside EXECUTE
        n_total++;
        if ({mem_req, exec_valid, opcode, operand} !== {1'b0, 1'b0, data})
            $display("FAIL decode: got req=%b ev=%b op=%b opd=%0d want req=0 ev=0 op=%b opd=%0d",
                     mem_req, exec_valid, opcode, operand, data[7:5], data[4:0]);
        else n_pass++;
        tick();
        jump = jmp;
        n_total++;
        if ({exec_valid, pc} !== {1'b1, addr})
            $display("FAIL execute: got ev=%b pc=%0d want ev=1 pc=%0d", exec_valid, pc, addr);
        else n_pass++;
        tick();
        jump = 1'b0;
        n_total++;
        if ({exec_valid, pc} !== {1'b0, exp_pc})
            $display("FAIL pc_update: got ev=%b pc=%0d want ev=0 pc=%0d", exec_valid, pc, exp_pc);
        else n_pass++;
    endtask

    task automatic test_basic();
        run = 1'b1;
        tick();
        exec_instr(8'b000_00011, 0, 1'b0, 5'd0, 5'd1);
    endtask

    task automatic test_jump();
        exec_instr(8'b000_00011, 0, 1'b1, 5'd1, 5'd3);
        n_total++;
        if ({mem_req, mem_addr} !== {1'b1, 5'd3})
            $display("FAIL jump_next_fetch: got req=%b addr=%0d want req=1 addr=3", mem_req, mem_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        exec_instr(8'b010_11111, 0, 1'b1, 5'd3, 5'd31);
        exec_instr(8'b001_00100, 0, 1'b0, 5'd31, 5'd0);
        n_total++;
        if ({mem_req, mem_addr} !== {1'b1, 5'd0})
            $display("FAIL wrap_next_fetch: got req=%b addr=%0d want req=1 addr=0", mem_req, mem_addr);
        else n_pass++;
    endtask

    task automatic test_wait();
        exec_instr(8'b010_00101, 5, 1'b0, 5'd0, 5'd1);
    endtask

    task automatic test_run_drop();
        run = 1'b0;
        exec_instr(8'b001_00010, 0, 1'b0, 5'd1, 5'd2);
        n_total++;
        if ({mem_req, halted} !== 2'b00)
            $display("FAIL run_drop_idle: got req=%b halt=%b want 0 0", mem_req, halted);
        else n_pass++;
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (3) tick();
        n_total++;
        if ({mem_req, pc, opcode, operand} !== {1'b0, 5'd2, 3'b001, 5'd2})
            $display("FAIL idle_ack_ignored: got req=%b pc=%0d op=%b opd=%0d want req=0 pc=2 op=001 opd=2",
                     mem_req, pc, opcode, operand);
        else n_pass++;
        run = 1'b1;
        tick();
    endtask

    task automatic test_halt();
        exec_instr(8'b111_00111, 0, 1'b0, 5'd2, 5'd3);
        n_total++;
        if ({halted, mem_req} !== 2'b10)
            $display("FAIL halt_enter: got halt=%b req=%b want halt=1 req=0", halted, mem_req);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            mem_ack = (i == 4);
            mem_rdata = 8'h1F;
            tick();
            n_total++;
            if ({halted, mem_req, pc, opcode} !== {1'b1, 1'b0, 5'd3, 3'b111})
                $display("FAIL halt_stuck[%0d]: got halt=%b req=%b pc=%0d op=%b want halt=1 req=0 pc=3 op=111",
                         i, halted, mem_req, pc, opcode);
            else n_pass++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        rst = 1'b1; run = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_total++;
        if ({mem_req, mem_addr, halted} !== {1'b1, 5'd0, 1'b0})
            $display("FAIL pre_reset_wait: got req=%b addr=%0d halt=%b want req=1 addr=0 halt=0",
                     mem_req, mem_addr, halted);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0;
        n_total++;
        if ({mem_req, pc, opcode, operand, halted, exec_valid} !== 16'h0)
            $display("FAIL reset_mid_wait: got req=%b pc=%0d op=%b opd=%0d halt=%b ev=%b want all 0",
                     mem_req, pc, opcode, operand, halted, exec_valid);
        else n_pass++;
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        tick();
        n_total++;
        if ({mem_req, opcode, operand, exec_valid} !== 10'h0)
            $display("FAIL late_ack_ignored: got req=%b op=%b opd=%0d ev=%b want all 0",
                     mem_req, opcode, operand, exec_valid);
        else n_pass++;
    endtask

    task automatic test_timeout();
        run = 1'b1;
        tick();
        tick();
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            n_total++;
            if ({mem_req, fault, halted} !== 3'b100)
                $display("FAIL timeout_wait[%0d]: got req=%b fault=%b halt=%b want 1 0 0",
                         i, mem_req, fault, halted);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({fault, halted, mem_req, pc} !== {1'b1, 1'b1, 1'b0, 5'd0})
            $display("FAIL timeout_fault: got fault=%b halt=%b req=%b pc=%0d want 1 1 0 0",
                     fault, halted, mem_req, pc);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        repeat (14) tick();
        mem_ack = 1'b1; mem_rdata = 8'b010_00001;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        n_total++;
        if ({fault, halted, mem_req, opcode, operand} !== {3'b000, 8'b010_00001})
            $display("FAIL ack_on_limit: got fault=%b halt=%b req=%b op=%b opd=%0d want 0 0 0 010 1",
                     fault, halted, mem_req, opcode, operand);
        else n_pass++;
`else
        for (int i = 0; i < 30; i++) begin
            n_total++;
            if ({mem_req, fault, halted} !== 3'b100)
                $display("FAIL no_timeout_wait[%0d]: got req=%b fault=%b halt=%b want 1 0 0",
                         i, mem_req, fault, halted);
            else n_pass++;
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 8'b010_00001;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        n_total++;
        if ({fault, halted, mem_req, opcode, operand} !== {3'b000, 8'b010_00001})
            $display("FAIL long_wait_load: got fault=%b halt=%b req=%b op=%b opd=%0d want 0 0 0 010 1",
                     fault, halted, mem_req, opcode, operand);
        else n_pass++;
`endif
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; jump = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_jump();
        test_wrap();
        test_wait();
        test_run_drop();
        test_halt();
        test_reset_in_wait();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
